// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite responder over a bank of byte-strobed 32-bit registers.
// Out-of-range accesses are answered with SLVERR and leave the bank untouched.
module axi4_lite_slave_regs #(
    parameter int G_ADDR_WIDTH = 16,
    parameter int G_NB_REG     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [G_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [31:0]               s_axi_wdata,
    input  logic [3:0]                s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [G_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [31:0]               s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [32*G_NB_REG-1:0]    o_regs,
    output logic [G_NB_REG-1:0]       o_wr_pulse
);

    localparam int IW = G_ADDR_WIDTH - 2;
    localparam int RW = (G_NB_REG > 1) ? $clog2(G_NB_REG) : 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t            r_wstate;
    r_state_t            r_rstate;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_aw_got;
    logic                r_w_got;
    logic [IW-1:0]       r_aw_idx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_arready;
    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [31:0]         r_rdata;
    logic [31:0]         r_regs [G_NB_REG];
    logic [G_NB_REG-1:0] r_wr_pulse;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_commit;
    logic [IW-1:0]       w_widx;
    logic [IW-1:0]       w_ridx;
    logic [RW-1:0]       w_wsel;
    logic [RW-1:0]       w_rsel;
    logic                w_wok;
    logic                w_rok;
    logic [31:0]         w_wd;
    logic [3:0]          w_ws;
    logic                w_unused;

    assign w_aw_hs  = s_axi_awvalid & r_awready;
    assign w_w_hs   = s_axi_wvalid & r_wready;
    assign w_ar_hs  = s_axi_arvalid & r_arready;
    // A channel arriving on the commit edge is used straight from the bus
    assign w_widx   = w_aw_hs ? s_axi_awaddr[G_ADDR_WIDTH-1:2] : r_aw_idx;
    assign w_wd     = w_w_hs ? s_axi_wdata : r_wdata;
    assign w_ws     = w_w_hs ? s_axi_wstrb : r_wstrb;
    assign w_commit = (r_wstate == W_IDLE) & (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
    assign w_ridx   = s_axi_araddr[G_ADDR_WIDTH-1:2];
    assign w_wok    = w_widx < IW'(G_NB_REG);
    assign w_rok    = w_ridx < IW'(G_NB_REG);
    assign w_wsel   = w_widx[RW-1:0];
    assign w_rsel   = w_ridx[RW-1:0];
    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_pulse <= '0;
            for (int i = 0; i < G_NB_REG; i++) r_regs[i] <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (r_wstate == W_IDLE) begin
                if (w_commit) begin
                    r_wstate  <= W_RESP;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_aw_got  <= 1'b0;
                    r_w_got   <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_bresp   <= w_wok ? 2'b00 : 2'b10;
                    if (w_wok) begin
                        r_wr_pulse[w_wsel] <= 1'b1;
                        for (int k = 0; k < 4; k++)
                            if (w_ws[k]) r_regs[w_wsel][8*k +: 8] <= w_wd[8*k +: 8];
                    end
                end else begin
                    r_awready <= ~(r_aw_got | w_aw_hs);
                    r_wready  <= ~(r_w_got | w_w_hs);
                    if (w_aw_hs) begin
                        r_aw_got <= 1'b1;
                        r_aw_idx <= s_axi_awaddr[G_ADDR_WIDTH-1:2];
                    end
                    if (w_w_hs) begin
                        r_w_got <= 1'b1;
                        r_wdata <= s_axi_wdata;
                        r_wstrb <= s_axi_wstrb;
                    end
                end
            end else if (s_axi_bready) begin
                r_wstate  <= W_IDLE;
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else if (r_rstate == R_IDLE) begin
            r_arready <= ~w_ar_hs;
            if (w_ar_hs) begin
                r_rstate <= R_DATA;
                r_rvalid <= 1'b1;
                r_rdata  <= w_rok ? r_regs[w_rsel] : 32'h0;
                r_rresp  <= w_rok ? 2'b00 : 2'b10;
            end
        end else if (s_axi_rready) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    for (genvar g = 0; g < G_NB_REG; g++) begin : g_regs
        assign o_regs[32*g +: 32] = r_regs[g];
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign o_wr_pulse    = r_wr_pulse;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// tb_axi4_lite_slave_regs: scenario tasks plus randomized traffic against a register-array model.
module tb_axi4_lite_slave_regs;

    localparam int AW = 16;
    localparam int NR = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   s_axi_awaddr = '0;
    logic            s_axi_awvalid = 1'b0;
    logic            s_axi_awready;
    logic [31:0]     s_axi_wdata = '0;
    logic [3:0]      s_axi_wstrb = '0;
    logic            s_axi_wvalid = 1'b0;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready = 1'b0;
    logic [AW-1:0]   s_axi_araddr = '0;
    logic            s_axi_arvalid = 1'b0;
    logic            s_axi_arready;
    logic [31:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready = 1'b0;
    logic [32*NR-1:0] o_regs;
    logic [NR-1:0]   o_wr_pulse;

    int total = 0;
    int bad = 0;
    logic [31:0] m_regs [NR];

    axi4_lite_slave_regs #(.G_ADDR_WIDTH(AW), .G_NB_REG(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .o_regs(o_regs), .o_wr_pulse(o_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
        bit a_hs, w_hs;
        ok = 0;
        resp = 2'b11;
        s_axi_awaddr = a; s_axi_awvalid = 1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
        s_axi_bready = 1;
        for (int i = 0; i < 20 && (s_axi_awvalid || s_axi_wvalid); i++) begin
            a_hs = s_axi_awvalid & s_axi_awready;
            w_hs = s_axi_wvalid & s_axi_wready;
            tick();
            if (a_hs) s_axi_awvalid = 0;
            if (w_hs) s_axi_wvalid = 0;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_axi_bvalid) begin
                resp = s_axi_bresp;
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        s_axi_bready = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp, output bit ok);
        bit hs;
        ok = 0;
        d = 'x;
        resp = 2'b11;
        s_axi_araddr = a; s_axi_arvalid = 1; s_axi_rready = 1;
        for (int i = 0; i < 20 && s_axi_arvalid; i++) begin
            hs = s_axi_arready;
            tick();
            if (hs) s_axi_arvalid = 0;
        end
        s_axi_arvalid = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_axi_rvalid) begin
                d = s_axi_rdata;
                resp = s_axi_rresp;
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        s_axi_rready = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        rst_n = 0;
        tick(); tick();
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0 ||
            {s_axi_bresp, s_axi_rresp} !== 4'b0 || s_axi_rdata !== 32'h0 || o_regs !== '0 || o_wr_pulse !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b regs=%h expected all zero",
                     s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, o_regs);
        end
        rst_n = 1;
        tick();
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            bad++;
            $display("FAIL reset_release_ready: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        do_read(16'h0000, d, r, ok);
        total++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin
            bad++;
            $display("FAIL reset_read0: got ok=%0d data=%h resp=%b expected data=00000000 resp=00", ok, d, r);
        end
    endtask

    task automatic test_full_write();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        s_axi_awaddr = 16'h0004; s_axi_awvalid = 1;
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1; s_axi_bready = 0;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        m_regs[1] = merge(m_regs[1], 32'hDEADBEEF, 4'hF);
        total++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || o_regs[63:32] !== m_regs[1] ||
            o_wr_pulse !== 8'b0000_0010 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
            bad++;
            $display("FAIL full_write_resp: got bv=%b bresp=%b reg1=%h pulse=%b expected bv=1 bresp=00 reg1=%h pulse=00000010",
                     s_axi_bvalid, s_axi_bresp, o_regs[63:32], o_wr_pulse, m_regs[1]);
        end
        s_axi_bready = 1;
        tick();
        s_axi_bready = 0;
        total++;
        if (s_axi_bvalid !== 1'b0 || o_wr_pulse !== '0 || {s_axi_awready, s_axi_wready} !== 2'b11) begin
            bad++;
            $display("FAIL full_write_after_b: got bv=%b pulse=%b rdy=%b%b expected bv=0 pulse=0 rdy=11",
                     s_axi_bvalid, o_wr_pulse, s_axi_awready, s_axi_wready);
        end
        do_read(16'h0004, d, r, ok);
        total++;
        if (!ok || d !== m_regs[1] || r !== 2'b00) begin
            bad++;
            $display("FAIL full_write_readback: got ok=%0d data=%h resp=%b expected %h 00", ok, d, r, m_regs[1]);
        end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        do_write(16'h0004, 32'h11223344, 4'b0101, r, ok);
        m_regs[1] = merge(m_regs[1], 32'h11223344, 4'b0101);
        total++;
        if (!ok || r !== 2'b00 || o_regs[63:32] !== m_regs[1] || m_regs[1] !== 32'hDE22BE44) begin
            bad++;
            $display("FAIL partial_strobe: got ok=%0d resp=%b reg1=%h expected 00 %h", ok, r, o_regs[63:32], m_regs[1]);
        end
        do_read(16'h0004, d, r, ok);
        total++;
        if (!ok || d !== 32'hDE22BE44 || r !== 2'b00) begin
            bad++;
            $display("FAIL partial_readback: got data=%h resp=%b expected de22be44 00", d, r);
        end
    endtask

    task automatic test_out_of_range();
        logic [32*NR-1:0] snap;
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        snap = o_regs;
        s_axi_awaddr = 16'h0020; s_axi_awvalid = 1;
        s_axi_wdata = $urandom; s_axi_wstrb = 4'hF; s_axi_wvalid = 1; s_axi_bready = 0;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        total++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b10 || o_wr_pulse !== '0 || o_regs !== snap) begin
            bad++;
            $display("FAIL oor_write: got bv=%b bresp=%b pulse=%b regs_changed=%0d expected bv=1 bresp=10 pulse=0 unchanged",
                     s_axi_bvalid, s_axi_bresp, o_wr_pulse, o_regs !== snap);
        end
        s_axi_bready = 1;
        tick();
        s_axi_bready = 0;
        do_read(16'h0020, d, r, ok);
        total++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            bad++;
            $display("FAIL oor_read: got data=%h resp=%b expected 00000000 10", d, r);
        end
    endtask

    task automatic test_skewed();
        int idx;
        int pulses;
        logic [31:0] d1;
        idx = $urandom_range(0, NR-1);
        d1 = $urandom;
        pulses = 0;
        s_axi_wdata = d1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1; s_axi_bready = 0;
        tick();
        pulses += int'(o_wr_pulse[idx]);
        total++;
        if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL skew_w_capture: got wready=%b bvalid=%b expected 0 0", s_axi_wready, s_axi_bvalid);
        end
        s_axi_wdata = ~d1;
        tick(); pulses += int'(o_wr_pulse[idx]);
        tick(); pulses += int'(o_wr_pulse[idx]);
        s_axi_awaddr = AW'(idx * 4); s_axi_awvalid = 1;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        m_regs[idx] = merge(m_regs[idx], d1, 4'hF);
        for (int i = 0; i < 5; i++) begin
            pulses += int'(o_wr_pulse[idx]);
            total++;
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
                bad++;
                $display("FAIL skew_b_hold%0d: got bv=%b bresp=%b expected 1 00", i, s_axi_bvalid, s_axi_bresp);
            end
            tick();
        end
        s_axi_bready = 1;
        tick();
        s_axi_bready = 0;
        total++;
        if (s_axi_bvalid !== 1'b0 || pulses != 1 || o_regs[32*idx +: 32] !== m_regs[idx]) begin
            bad++;
            $display("FAIL skew_result: got bv=%b pulses=%0d reg=%h expected bv=0 pulses=1 reg=%h",
                     s_axi_bvalid, pulses, o_regs[32*idx +: 32], m_regs[idx]);
        end
        s_axi_araddr = AW'(idx * 4); s_axi_arvalid = 1; s_axi_rready = 0;
        tick();
        s_axi_arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== m_regs[idx] || s_axi_rresp !== 2'b00) begin
                bad++;
                $display("FAIL skew_r_hold%0d: got rv=%b data=%h expected 1 %h", i, s_axi_rvalid, s_axi_rdata, m_regs[idx]);
            end
            if (i < 4) tick();
        end
        s_axi_rready = 1;
        tick();
        s_axi_rready = 0;
        total++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            bad++;
            $display("FAIL skew_r_done: got rv=%b arready=%b expected 0 1", s_axi_rvalid, s_axi_arready);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_v, new_v;
        old_v = m_regs[2];
        new_v = $urandom;
        s_axi_araddr = 16'h0008; s_axi_arvalid = 1; s_axi_rready = 1;
        s_axi_awaddr = 16'h000B; s_axi_awvalid = 1;
        s_axi_wdata = new_v; s_axi_wstrb = 4'hF; s_axi_wvalid = 1; s_axi_bready = 1;
        tick();
        s_axi_arvalid = 0; s_axi_awvalid = 0; s_axi_wvalid = 0;
        m_regs[2] = new_v;
        total++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old_v || s_axi_bvalid !== 1'b1 || o_regs[95:64] !== new_v) begin
            bad++;
            $display("FAIL collision: got rv=%b rdata=%h bv=%b reg2=%h expected 1 %h 1 %h",
                     s_axi_rvalid, s_axi_rdata, s_axi_bvalid, o_regs[95:64], old_v, new_v);
        end
        tick();
        s_axi_rready = 0; s_axi_bready = 0;
    endtask

    task automatic test_random();
        int idx;
        logic [AW-1:0] a;
        logic [31:0] d;
        logic [3:0] s;
        logic [1:0] r;
        bit ok;
        for (int n = 0; n < 40; n++) begin
            idx = ($urandom_range(0, 9) == 9) ? int'($urandom_range(NR, 16383)) : int'($urandom_range(0, NR));
            a = AW'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                do_write(a, d, s, r, ok);
                if (idx < NR) m_regs[idx] = merge(m_regs[idx], d, s);
                total++;
                if (!ok || r !== ((idx < NR) ? 2'b00 : 2'b10)) begin
                    bad++;
                    $display("FAIL rand_write%0d: addr=%h got ok=%0d resp=%b", n, a, ok, r);
                end
            end else begin
                do_read(a, d, r, ok);
                total++;
                if (!ok || d !== ((idx < NR) ? m_regs[idx] : 32'h0) || r !== ((idx < NR) ? 2'b00 : 2'b10)) begin
                    bad++;
                    $display("FAIL rand_read%0d: addr=%h got data=%h resp=%b expected %h",
                             n, a, d, r, (idx < NR) ? m_regs[idx] : 32'h0);
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            total++;
            if (o_regs[32*i +: 32] !== m_regs[i]) begin
                bad++;
                $display("FAIL rand_regs%0d: got %h expected %h", i, o_regs[32*i +: 32], m_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        s_axi_awaddr = 16'h000C; s_axi_awvalid = 1;
        s_axi_wdata = $urandom | 32'h1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1; s_axi_bready = 0;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        total++;
        if (s_axi_bvalid !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_setup: got bv=%b expected 1", s_axi_bvalid);
        end
        rst_n = 0;
        tick();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        total++;
        if (s_axi_bvalid !== 1'b0 || o_regs !== '0) begin
            bad++;
            $display("FAIL mid_reset: got bv=%b regs=%h expected 0 0", s_axi_bvalid, o_regs);
        end
        rst_n = 1;
        s_axi_bready = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (s_axi_bvalid !== 1'b0 || o_wr_pulse !== '0) begin
                bad++;
                $display("FAIL mid_reset_after%0d: got bv=%b pulse=%b expected 0 0", i, s_axi_bvalid, o_wr_pulse);
            end
        end
        s_axi_bready = 0;
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_partial_strobe();
        test_out_of_range();
        test_skewed();
        test_collision();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
